ps2_kbd_decoder: RTL

- Consumes the received-byte stream of the PS/2 host controller (rx_data with rx_ack/rx_err strobes) and decodes scan-code set 2 into key events.
- Handles the E0, F0 and E1 (Pause) prefix sequences.
- Queues events in a small show-ahead FIFO for a bus/CPU reader.
- Reports device response bytes (ACK, BAT, echo, resend, overrun) separately and counts receive errors.

---
 rtl/ps2_kbd_pkg.sv | 51 +++++
 rtl/ps2_kbd_decoder_if.sv | 34 +++
 rtl/ps2_evt_fifo.sv | 58 +++++
 rtl/ps2_kbd_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 set-2 decoder: state encoding, prefix and response bytes, event layout.
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } dec_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_ERR2 = 8'hFD;
    localparam logic [7:0] RSP_ECHO     = 8'hEE;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_OVR_00   = 8'h00;
    localparam logic [7:0] RSP_OVR_FF   = 8'hFF;

    localparam int EV_W   = 10;
    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;

    // Bytes still to swallow after the leading E1 of a Pause sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == RSP_OVR_00) || (b == RSP_OVR_FF);
    endfunction

    function automatic logic is_resp(input logic [7:0] b);
        return (b == RSP_ACK) || (b == RSP_BAT_OK) || (b == RSP_BAT_ERR) ||
               (b == RSP_BAT_ERR2) || (b == RSP_ECHO) || (b == RSP_RESEND);
    endfunction

    function automatic logic [EV_W-1:0] mk_ev(input logic brk, input logic ext,
                                             input logic [7:0] code);
        logic [EV_W-1:0] v;
        v         = '0;
        v[EV_BRK] = brk;
        v[EV_EXT] = ext;
        v[7:0]    = code;
        return v;
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// Byte-in / event-out bundle of the decoder; master drives bytes and reads, slave is the decoder.
interface ps2_kbd_decoder_if #(
    parameter int FIFO_DEPTH = 8
);
    import ps2_kbd_pkg::*;

    logic [7:0]                    rx_data;
    logic                          rx_ack;
    logic                          rx_err;
    logic                          rd_en;
    logic                          clr;
    logic [EV_W-1:0]               ev_data;
    logic                          ev_empty;
    logic                          ev_full;
    logic [$clog2(FIFO_DEPTH):0]   ev_count;
    logic                          overflow;
    logic                          resp_valid;
    logic [7:0]                    resp_data;
    logic [7:0]                    err_cnt;
    logic [2:0]                    dec_state;

    modport master (
        output rx_data, rx_ack, rx_err, rd_en, clr,
        input  ev_data, ev_empty, ev_full, ev_count, overflow,
               resp_valid, resp_data, err_cnt, dec_state
    );

    modport slave (
        input  rx_data, rx_ack, rx_err, rd_en, clr,
        output ev_data, ev_empty, ev_full, ev_count, overflow,
               resp_valid, resp_data, err_cnt, dec_state
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO: a push appears at dout on the same edge it is written, pops take one cycle.
// No backpressure: a push while full (no pop) is refused and reported on drop for the parent to latch.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !pop;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Set-2 scan-code decoder: byte in, event visible at the FIFO head one clk edge after rx_ack.
// No backpressure to the receiver; events arriving at a full FIFO are dropped and flagged on overflow.
module ps2_kbd_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int CLK_FREQ   = 100,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps2_kbd_decoder_if.slave     bus
);
    localparam int TMO_CYC = TIMEOUT_US * CLK_FREQ;
    localparam int TMR_W   = $clog2(TMO_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);

    dec_state_t       state;
    dec_state_t       state_n;
    logic [2:0]       skip;
    logic [2:0]       skip_n;
    logic [TMR_W-1:0] tmr;
    logic             push;
    logic [EV_W-1:0]  push_dat;
    logic             resp_hit;
    logic             resp_vld_q;
    logic [7:0]       resp_q;
    logic [7:0]       err_q;
    logic             ovf_q;
    logic             drop;
    logic [7:0]       b;

    assign b = bus.rx_data;

    always_comb begin
        state_n  = state;
        skip_n   = skip;
        push     = 1'b0;
        push_dat = '0;
        resp_hit = 1'b0;
        if (bus.rx_err) begin
            state_n = ST_IDLE;
        end else if (bus.rx_ack) begin
            if (is_overrun(b)) begin
                resp_hit = 1'b1;
                state_n  = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (b == PFX_E0) begin
                            state_n = ST_E0;
                        end else if (b == PFX_F0) begin
                            state_n = ST_F0;
                        end else if (b == PFX_E1) begin
                            state_n = ST_PAUSE;
                            skip_n  = PAUSE_SKIP;
                        end else if (is_resp(b)) begin
                            resp_hit = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_dat = mk_ev(1'b0, 1'b0, b);
                        end
                    end
                    ST_E0: begin
                        if (b == PFX_F0) begin
                            state_n = ST_E0F0;
                        end else begin
                            push     = 1'b1;
                            push_dat = mk_ev(1'b0, 1'b1, b);
                            state_n  = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        push     = 1'b1;
                        push_dat = mk_ev(1'b1, 1'b0, b);
                        state_n  = ST_IDLE;
                    end
                    ST_E0F0: begin
                        push     = 1'b1;
                        push_dat = mk_ev(1'b1, 1'b1, b);
                        state_n  = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        // Pause has no break code; the whole 8-byte burst is one extended E1 make.
                        skip_n = skip - 3'd1;
                        if (skip == 3'd1) begin
                            push     = 1'b1;
                            push_dat = mk_ev(1'b0, 1'b1, PFX_E1);
                            state_n  = ST_IDLE;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end else if ((state != ST_IDLE) && (tmr == TMR_LAST)) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            skip  <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
        end
    end

    // Inter-byte gap timer; only meaningful while a multi-byte sequence is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if ((state == ST_IDLE) || bus.rx_ack || bus.rx_err) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
            err_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            resp_vld_q <= resp_hit;
            if (resp_hit) resp_q <= b;
            // clr first, then the same-cycle error counts from zero.
            if (bus.clr) begin
                err_q <= {7'd0, bus.rx_err};
            end else if (bus.rx_err && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            if (bus.clr) begin
                ovf_q <= drop;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.rd_en),
        .din   (push_dat),
        .dout  (bus.ev_data),
        .full  (bus.ev_full),
        .empty (bus.ev_empty),
        .count (bus.ev_count),
        .drop  (drop)
    );

    assign bus.overflow   = ovf_q;
    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_data  = resp_q;
    assign bus.err_cnt    = err_q;
    assign bus.dec_state  = state;

endmodule
